// File: rtl/sync_fifo_256x32b_pkg.sv
// Shared types and constants for the 256x32b FIFO stream reader.
// Holds the FSM encoding, the default word width and the ring-pointer helper.
package sync_fifo_256x32b_pkg;

    localparam int DEFAULT_W = 32;
    localparam int BUF_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Ring pointers wrap at 3, not at the natural 2-bit boundary.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_256x32b_stream_reader_buf.sv
// Three-entry ring buffer between the FIFO read data and the output stream.
// Head word is presented combinationally and reads as zero when empty.
module sync_fifo_256x32b_stream_reader_buf
    import sync_fifo_256x32b_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [BUF_DEPTH];
    logic [1:0]   wr_ptr_q;
    logic [1:0]   rd_ptr_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_d;

    // NOTE: storage is deliberately left out of reset; occ gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q <= occ_d;
        end
    end

    assign head_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o  = occ_q;

    // The issue rule keeps occ+inflight <= 3, so a capture into a full buffer is a design bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && (occ_q == 2'd3) && !pop_i));

endmodule

// File: rtl/sync_fifo_256x32b_stream_reader.sv
// Drains the FIFO read port (1-cycle latency) into a full-throughput valid/ready stream
// with a burst-boundary flag, plus enable/stop with a clean drain.
module sync_fifo_256x32b_stream_reader
    import sync_fifo_256x32b_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int BURST_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [W-1:0] fifo_rd_data,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [W-1:0] data_out,
    output logic         data_out_last,
    output logic         busy
);

    localparam int                CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_e           state_q;
    logic             inflight_q;
    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] beat_d;
    logic [1:0]       occ;
    logic [2:0]       pending;
    logic             pop;
    logic             drain_done;

    sync_fifo_256x32b_stream_reader_buf #(.W(W)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop),
        .head_o      (data_out),
        .occ_o       (occ)
    );

    // Reserve a slot for the word already in flight; enable gates the strobe in the stop cycle itself.
    assign pending    = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en = (state_q == RUN) & enable & ~fifo_empty & (pending <= 3'd2);

    assign data_out_valid = (occ != 2'd0);
    assign pop            = data_out_valid & data_out_ready;
    assign data_out_last  = data_out_valid & (beat_q == LAST_BEAT);
    assign busy           = (state_q != IDLE);
    assign drain_done     = ~inflight_q & ((occ == 2'd0) | ((occ == 2'd1) & pop));

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            beat_q     <= beat_d;
            case (state_q)
                IDLE:    if (enable) state_q <= RUN;
                RUN:     if (!enable) state_q <= DRAIN;
                DRAIN: begin
                    if (enable)          state_q <= RUN;
                    else if (drain_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
